// File: rtl/ldo_tau_trim_sar.sv
// rtl/ldo_tau_trim_sar.sv - SAR trim search over VREG against a settled regulator-model sample
module ldo_tau_trim_sar #(
    parameter int CODE_W        = 9,
    parameter int MEAS_W        = 7,
    parameter int SETTLE_CYCLES = 64,
    parameter int VREF_CODE     = 256,
    parameter int VREG_INIT     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MEAS_W-1:0] target,
    input  logic [MEAS_W-1:0] meas,
    output logic [CODE_W-1:0] vref,
    output logic [CODE_W-1:0] vreg,
    output logic              model_rst,
    output logic              busy,
    output logic              done,
    output logic              valid
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(CODE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_dec;
    logic [MEAS_W-1:0] target_q;
    logic [CODE_W-1:0] cur_mask;
    logic [CODE_W-1:0] next_mask;
    logic              keep_bit;

    // VREF is a fixed reference for the whole calibration
    assign vref = CODE_W'(VREF_CODE);

    // One-hot masks for the bit under trial and the next lower bit to try
    always_comb begin
        cur_mask    = '0;
        next_mask   = '0;
        bit_idx_dec = bit_idx - 1'b1;
        cur_mask[bit_idx] = 1'b1;
        if (bit_idx != '0) begin
            next_mask[bit_idx_dec] = 1'b1;
        end
        // Equal counts as "not above target", so the bit is dropped
        keep_bit = (meas > target_q);
    end

    // Search sequencer: restart the model, let it settle, judge one bit, repeat MSB to LSB
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            target_q  <= '0;
            vreg      <= CODE_W'(VREG_INIT);
            model_rst <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        target_q  <= target;
                        bit_idx   <= IDX_TOP;
                        vreg      <= '0;
                        vreg[CODE_W-1] <= 1'b1;
                        valid     <= 1'b0;
                        busy      <= 1'b1;
                        model_rst <= 1'b1;
                        state     <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    model_rst <= 1'b0;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECIDE: begin
                    // Clear the trial bit if the sample failed, then arm the next trial bit
                    if (bit_idx == '0) begin
                        vreg  <= keep_bit ? vreg : (vreg & ~cur_mask);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        vreg      <= (keep_bit ? vreg : (vreg & ~cur_mask)) | next_mask;
                        bit_idx   <= bit_idx_dec;
                        model_rst <= 1'b1;
                        state     <= S_APPLY;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
